im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot-time program loader upstream of the instruction memory (im) and the core (top).
- Accepts a byte stream with a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into im through its IM_* port.
- Holds the core in reset until the image is fully written, so the core starts fetching from address 0 with the program in place.
- Replaces bench-side direct memory preloading with a synthesizable load path.

Parameters:
- IM_ADDR_W, 10, width of the byte address driven on IM_address.
- MAX_WORDS, 256, im capacity in words; equals 2**(IM_ADDR_W-2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- IM_read  output  1  always 0 (the loader only writes).
- IM_write  output  1  write strobe to im.
- IM_enable  output  1  im enable.
- IM_address  output  IM_ADDR_W  byte address; always word-aligned (word_idx*4).
- IMin  output  32  write data to im.
- cpu_rst  output  1  reset to top; high until load completes.
- done  output  1  load complete.
- err  output  1  load failed.

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - state=HDR0, word_idx=0, byte_cnt=0, count=0.
  - in_ready=0 during reset; it goes high the first cycle after reset deasserts.
  - IM_write=0, IM_enable=0, IM_read=0, IM_address=0, IMin=0.
  - cpu_rst=1, done=0, err=0.
- Transfer rule: a byte is taken on a rising edge where in_valid and in_ready are both 1. in_data is ignored otherwise.
- Stream format:
  - count_lo, count_hi: 16-bit word count, little-endian.
  - Then count words, 4 bytes each, LSB first.
- States:
  - HDR0: in_ready=1. On transfer, latch count[7:0] and go to HDR1.
  - HDR1: in_ready=1. On transfer, latch count[15:8]. Then:
    - full count=0 -> DONE;
    - full count>MAX_WORDS -> ERROR;
    - otherwise -> DATA.
  - DATA: in_ready=1. Each transfer shifts the byte into word[8*byte_cnt +: 8] and increments byte_cnt. On the 4th byte, go to WRITE.
  - WRITE: exactly one cycle. in_ready=0, IM_enable=1, IM_write=1, IM_address=word_idx<<2, IMin=assembled word. Next cycle:
    - word_idx++ and byte_cnt=0;
    - if word_idx was count-1 -> DONE, else -> DATA.
  - DONE: terminal. in_ready=0, cpu_rst=0, done=1. Only rst leaves this state.
  - ERROR: terminal. in_ready=0, cpu_rst=1, err=1, no im writes. Only rst leaves this state.
- Outside WRITE, IM_write and IM_enable are 0. IM_address and IMin hold their last values.
- Latency: the im write occurs exactly 1 cycle after the 4th byte of a word is accepted.
- Throughput: at most 1 word per 5 cycles, because in_ready drops in WRITE.
- Reset mid-load:
  - everything returns to HDR0 immediately (asynchronous);
  - words already written stay in im;
  - cpu_rst stays 1.
- Bytes that arrive after DONE or ERROR are never accepted (in_ready=0).
- count=MAX_WORDS is legal. The last address written is (MAX_WORDS-1)*4; no wrap-around.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - one extra byte follows the last word; it is the XOR of all header and data bytes;
  - the FSM goes through a CSUM state (in_ready=1) instead of going straight from the last WRITE, or from HDR1 when count=0, to DONE;
  - match -> DONE; mismatch -> ERROR (cpu_rst stays 1, err=1).
- Undefined:
  - no trailing byte and no CSUM state; the XOR accumulator is not built.

Decomposition:
- Shared package/include (loader_defs.v):
  - state encodings HDR0/HDR1/DATA/WRITE/CSUM/DONE/ERROR;
  - header length (2 bytes);
  - byte-lane constant (4 bytes per word).
- Natural sub-module: im_loader_asm, the byte-to-word assembler. It holds byte_cnt, the word register, the "word_full" flag and the XOR accumulator.
- The top FSM and the im interface stay in im_loader.

Test Plan:
- Basic load: stream 03 00, EF BE AD DE, 01 00 00 00, 78 56 34 12 with in_valid held high.
  - im words 0..2 = DEADBEEF, 00000001, 12345678;
  - IM_address sequence 0, 4, 8;
  - cpu_rst falls and done rises the cycle after the 3rd write.
- Zero count: stream 00 00.
  - DONE 1 cycle after the 2nd byte; no IM_write pulse ever.
- Oversize: stream 01 01 (count 257).
  - ERROR; err=1, cpu_rst=1, in_ready=0; no im writes; any further bytes are ignored.
- Backpressure/gaps: same stream as basic load, but with random in_valid gaps of 0-3 cycles.
  - identical im contents;
  - no byte is lost or duplicated;
  - IM_write is never asserted while in_ready=1.
- Reset mid-load: assert rst after 6 bytes, then replay the full basic stream.
  - state restarts at HDR0; final im contents match the basic-load case; done=1.
- With IM_LOADER_CHECKSUM_EN:
  - stream 01 00 11 22 33 44 + checksum 45 (XOR of 01,00,11,22,33,44) -> done=1;
  - same stream with checksum 46 -> err=1, cpu_rst stays 1.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader shared definitions: FSM state encodings, header and word geometry.
// Optional feature macro: IM_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
package im_loader_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } state_e;

    // Header carries a little-endian word count
    localparam int unsigned HdrBytes     = 2;
    localparam int unsigned CountW       = 8 * HdrBytes;

    // Byte lanes per instruction word
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned LaneW        = $clog2(BytesPerWord);
    localparam int unsigned WordW        = 8 * BytesPerWord;

    // States in which the loader takes stream bytes
    function automatic logic accepts_bytes(input state_e st);
        return (st == StHdr0) || (st == StHdr1) || (st == StData) || (st == StCsum);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// im_loader bus bundle: incoming byte stream plus the write port into im.
// master = the loader (drives the im port, sinks the stream);
// slave  = the environment (sources the stream, hosts im).
// Optional feature macro: IM_LOADER_CHECKSUM_EN (no effect on this bundle).
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int unsigned IM_ADDR_W = 10
) ();

    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 IM_read;
    logic                 IM_write;
    logic                 IM_enable;
    logic [IM_ADDR_W-1:0] IM_address;
    logic [WordW-1:0]     IMin;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output IM_read,
        output IM_write,
        output IM_enable,
        output IM_address,
        output IMin
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  IM_read,
        input  IM_write,
        input  IM_enable,
        input  IM_address,
        input  IMin
    );

endinterface

// File: rtl/im_loader_asm.sv
// im_loader_asm: byte-to-word assembler. Places accepted data bytes into
// little-endian lanes, flags a completed word for one cycle and, when
// IM_LOADER_CHECKSUM_EN is defined, keeps a running XOR of every stream byte.
module im_loader_asm
    import im_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             take,       // data byte accepted this cycle
    input  logic [7:0]       data,
`ifdef IM_LOADER_CHECKSUM_EN
    input  logic             acc_en,     // any header or data byte accepted
    output logic [7:0]       csum,
`endif
    output logic             last_lane,  // next accepted byte completes the word
    output logic             word_full,  // high the cycle after a word completes
    output logic [WordW-1:0] word_next   // word including the byte being taken
);

    logic [LaneW-1:0] byte_cnt_q;
    logic [WordW-1:0] word_q;
    logic             word_full_q;

    // Merge the incoming byte into its lane so the completed word is visible at once
    always_comb begin
        last_lane = (byte_cnt_q == LaneW'(BytesPerWord - 1));
        word_next = word_q;
        if (take) begin
            word_next[{byte_cnt_q, 3'b000} +: 8] = data;
        end
    end

    assign word_full = word_full_q;

    // Lane counter wraps to zero after the last lane, ready for the next word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            word_q      <= '0;
            word_full_q <= 1'b0;
        end else begin
            word_q      <= word_next;
            word_full_q <= take && last_lane;
            if (take) begin
                byte_cnt_q <= byte_cnt_q + LaneW'(1);
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // XOR of header and data bytes; the checksum byte itself is not folded in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (acc_en) begin
            csum_q <= csum_q ^ data;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: rtl/im_loader.sv
// im_loader: boot-time program loader. Reads a little-endian word count and
// that many 32-bit words from a byte stream, writes them into im from address
// 0 upward and holds the core in reset until the image is in place.
// Optional feature macro: IM_LOADER_CHECKSUM_EN (trailing XOR checksum byte,
// mismatch ends in the error state).
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned IM_ADDR_W = 10,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.master bus,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam logic [CountW:0] MaxCount = (CountW + 1)'(MAX_WORDS);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_e AfterLast = StCsum;
`else
    localparam state_e AfterLast = StDone;
`endif

    state_e               state_q, state_d;
    logic [CountW-1:0]    count_q;
    logic [CountW-1:0]    word_idx_q;
    logic                 in_ready_q;
    logic                 im_write_q;
    logic [IM_ADDR_W-1:0] addr_q;
    logic [WordW-1:0]     imin_q;
    logic                 cpu_rst_q;
    logic                 done_q;
    logic                 err_q;

    logic                 xfer;
    logic                 take;
    logic                 last_lane;
    logic                 word_full;
    logic [WordW-1:0]     word_next;
    logic [CountW-1:0]    count_full;
    logic                 last_word;

    assign xfer       = bus.in_valid && in_ready_q;
    assign take       = xfer && (state_q == StData);
    assign count_full = {bus.in_data, count_q[7:0]};
    assign last_word  = (word_idx_q == count_q - CountW'(1));

`ifdef IM_LOADER_CHECKSUM_EN
    logic       acc_en;
    logic [7:0] csum;

    assign acc_en = xfer && ((state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData));
`endif

    im_loader_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .take      (take),
        .data      (bus.in_data),
`ifdef IM_LOADER_CHECKSUM_EN
        .acc_en    (acc_en),
        .csum      (csum),
`endif
        .last_lane (last_lane),
        .word_full (word_full),
        .word_next (word_next)
    );

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdr0: begin
                if (xfer) begin
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (xfer) begin
                    if (count_full == '0) begin
                        state_d = AfterLast;
                    end else if ({1'b0, count_full} > MaxCount) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer && last_lane) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (word_full) begin
                    state_d = last_word ? AfterLast : StData;
                end
            end
            StCsum: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_d = (bus.in_data == csum) ? StDone : StError;
                end
`else
                state_d = StError;  // not reachable without the checksum option
`endif
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // State, counters and registered outputs (outputs follow the state being entered)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHdr0;
            count_q    <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b0;
            im_write_q <= 1'b0;
            addr_q     <= '0;
            imin_q     <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer && (state_q == StHdr0)) begin
                count_q[7:0] <= bus.in_data;
            end
            if (xfer && (state_q == StHdr1)) begin
                count_q[15:8] <= bus.in_data;
            end
            if (state_q == StWrite) begin
                word_idx_q <= word_idx_q + CountW'(1);
            end
            // Address and data are only loaded on entry to the write cycle and hold otherwise
            if (state_d == StWrite) begin
                addr_q <= {word_idx_q[IM_ADDR_W-3:0], 2'b00};
                imin_q <= word_next;
            end
            in_ready_q <= accepts_bytes(state_d);
            im_write_q <= (state_d == StWrite);
            cpu_rst_q  <= (state_d != StDone);
            done_q     <= (state_d == StDone);
            err_q      <= (state_d == StError);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.IM_read    = 1'b0;
    assign bus.IM_write   = im_write_q;
    assign bus.IM_enable  = im_write_q;
    assign bus.IM_address = addr_q;
    assign bus.IMin       = imin_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed bench for im_loader. Expected im writes are queued
// as stimulus is issued; a monitor pops and compares on every IM_write pulse.
// Build with IM_LOADER_CHECKSUM_EN defined to exercise the checksum option.
module tb_im_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst;
    logic done;
    logic err;

    im_loader_if #(.IM_ADDR_W(10)) bus ();

    im_loader #(
        .IM_ADDR_W (10),
        .MAX_WORDS (256)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          wr_count = 0;
    logic [9:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] im_model[0:255];
    logic [7:0]  stream_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor: acts as im and scoreboard
    always @(negedge clk) begin
        logic [9:0]  ea;
        logic [31:0] ed;
        if (!rst && bus.IM_write) begin
            check("wr_flags{en,ready,read}", {29'd0, bus.IM_enable, bus.in_ready, bus.IM_read},
                  32'b100);
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         bus.IM_address, bus.IMin);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", {22'd0, bus.IM_address}, {22'd0, ea});
                check("wr_data", bus.IMin, ed);
            end
            im_model[bus.IM_address[9:2]] <= bus.IMin;
            wr_count++;
        end
    end

    task automatic expect_write(input logic [9:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic push_basic_writes();
        expect_write(10'h000, 32'hDEADBEEF);
        expect_write(10'h004, 32'h00000001);
        expect_write(10'h008, 32'h12345678);
    endtask

    task automatic load_basic_stream();
        stream_q = {8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00,
                    8'h78, 8'h56, 8'h34, 8'h12};
`ifdef IM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h28);
`endif
    endtask

    task automatic clear_im();
        for (int i = 0; i < 256; i++) im_model[i] = 32'hxxxxxxxx;
    endtask

    task automatic check_basic_im(input string tag);
        check({tag, "_im0"}, im_model[0], 32'hDEADBEEF);
        check({tag, "_im1"}, im_model[1], 32'h00000001);
        check({tag, "_im2"}, im_model[2], 32'h12345678);
        check({tag, "_pending"}, exp_addr_q.size(), 0);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h got in_ready 0, expected 1 within 50 cycles", b);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        while (stream_q.size() > 0) begin
            send_byte(stream_q.pop_front(), (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic wait_flag(input string name, input logic want_err);
        int n = 0;
        while (!(want_err ? err : done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (want_err ? err : done)}, 32'd1);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ctrl{rdy,cpu_rst,done,err,wr,en,rd}",
              {25'd0, bus.in_ready, cpu_rst, done, err, bus.IM_write, bus.IM_enable, bus.IM_read},
              32'b0100000);
        check("rst_addr", {22'd0, bus.IM_address}, 32'd0);
        check("rst_imin", bus.IMin, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int         wr0;
        int         seen_ready;
        logic [7:0] last_b;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Basic load, valid held high
        clear_im();
        do_reset();
        push_basic_writes();
        load_basic_stream();
`ifndef IM_LOADER_CHECKSUM_EN
        last_b = stream_q.pop_back();
        send_stream(0);
        send_byte(last_b, 0);
        check("basic_wr_latency", {31'd0, bus.IM_write}, 32'd1);
        check("basic_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("basic_done_timing{done,cpu_rst,wr}", {29'd0, done, cpu_rst, bus.IM_write}, 32'b100);
`else
        send_stream(0);
`endif
        wait_flag("basic_done", 1'b0);
        check("basic_final{rdy,cpu_rst,err}", {29'd0, bus.in_ready, cpu_rst, err}, 32'b000);
        check_basic_im("basic");

        // Zero count
        do_reset();
        wr0 = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
        check("zero_csum_wait", {31'd0, done}, 32'd0);
        send_byte(8'h00, 0);
`endif
        check("zero_done{done,cpu_rst,err}", {29'd0, done, cpu_rst, err}, 32'b100);
        repeat (3) @(negedge clk);
        check("zero_no_write", wr_count, wr0);

        // Oversize count 257
        do_reset();
        wr0 = wr_count;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("ovr_state{err,cpu_rst,rdy,done}", {28'd0, err, cpu_rst, bus.in_ready, done},
              32'b1100);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        seen_ready   = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready) seen_ready++;
        end
        bus.in_valid = 1'b0;
        check("ovr_ignore_bytes", seen_ready, 0);
        check("ovr_err_held", {31'd0, err}, 32'd1);
        check("ovr_no_write", wr_count, wr0);

        // Backpressure gaps
        clear_im();
        do_reset();
        push_basic_writes();
        load_basic_stream();
        send_stream(3);
        wait_flag("gap_done", 1'b0);
        check_basic_im("gap");

        // Reset mid-load after 6 bytes, then replay
        clear_im();
        do_reset();
        expect_write(10'h000, 32'hDEADBEEF);
        load_basic_stream();
        repeat (6) send_byte(stream_q.pop_front(), 0);
        repeat (2) @(negedge clk);
        check("mid_first_word_written", exp_addr_q.size(), 0);
        stream_q.delete();
        rst = 1'b1;
        #1;
        check("mid_async{rdy,cpu_rst,done}", {29'd0, bus.in_ready, cpu_rst, done}, 32'b010);
        do_reset();
        push_basic_writes();
        load_basic_stream();
        send_stream(0);
        wait_flag("mid_done", 1'b0);
        check_basic_im("mid");

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum match
        do_reset();
        expect_write(10'h000, 32'h44332211);
        stream_q = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_stream(0);
        wait_flag("csum_ok_done", 1'b0);
        check("csum_ok{cpu_rst,err}", {30'd0, cpu_rst, err}, 32'b00);

        // Checksum mismatch
        do_reset();
        expect_write(10'h000, 32'h44332211);
        stream_q = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        send_stream(0);
        wait_flag("csum_bad_err", 1'b1);
        check("csum_bad{cpu_rst,done}", {30'd0, cpu_rst, done}, 32'b10);
        check("csum_pending", exp_addr_q.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
